// File: rtl/cache_miss_ctrl.sv
// Miss sequencer for a 4-way set-associative cache: lookup, optional dirty-victim
// writeback, line refill and install; owns the memory-bus handshake and CPU stall.
module cache_miss_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int INDEX_WIDTH    = 6,
   parameter int WORDS_PER_LINE = 4,
   parameter int OFFSET         = 4,
   parameter int TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - OFFSET
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              cpu_req,
   input  logic [ADDR_WIDTH-1:0]             cpu_addr,
   input  logic [3:0]                        hit_en,
   input  logic [2:0]                        replaced_way,
   input  logic                              victim_dirty,
   input  logic [TAG_WIDTH-1:0]              victim_tag,
   input  logic [DATA_WIDTH-1:0]             line_rdata,
   input  logic                              mem_ack,
   input  logic [DATA_WIDTH-1:0]             mem_rdata,
   output logic                              cache_en,
   output logic                              cpu_stall,
   output logic                              mem_req,
   output logic                              mem_we,
   output logic [ADDR_WIDTH-1:0]             mem_addr,
   output logic [DATA_WIDTH-1:0]             mem_wdata,
   output logic [1:0]                        way_sel,
   output logic [$clog2(WORDS_PER_LINE)-1:0] word_sel,
   output logic                              data_we,
   output logic                              tag_we,
   output logic                              fill_done
);

   localparam int CNT_W  = $clog2(WORDS_PER_LINE);
   localparam int BYTE_W = OFFSET - CNT_W;
   localparam int LINE_W = ADDR_WIDTH - OFFSET;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOOKUP  = 3'd1,
      WBACK   = 3'd2,
      REFILL  = 3'd3,
      INSTALL = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [1:0]             way_q, way_d;
   logic [LINE_W-1:0]      addr_q, addr_d;
   logic [TAG_WIDTH-1:0]   vtag_q, vtag_d;

   logic                   hit;
   logic [1:0]             hit_way;
   logic                   last_beat;
   logic [INDEX_WIDTH-1:0] index;
   logic [TAG_WIDTH-1:0]   req_tag;
   logic                   unused_addr_bits;

   // Only the line address is kept; byte offset bits of the request never matter.
   assign unused_addr_bits = ^cpu_addr[OFFSET-1:0];

   assign index     = addr_q[INDEX_WIDTH-1:0];
   assign req_tag   = addr_q[LINE_W-1:INDEX_WIDTH];
   assign hit       = |hit_en;
   assign last_beat = (cnt_q == CNT_W'(WORDS_PER_LINE - 1));

   // Lowest-numbered hitting way wins when several ways report a hit.
   always_comb begin
      hit_way = 2'd0;
      for (int w = 3; w >= 0; w--) begin
         if (hit_en[w]) hit_way = 2'(w);
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      way_d     = way_q;
      addr_d    = addr_q;
      vtag_d    = vtag_q;
      cache_en  = 1'b0;
      cpu_stall = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      way_sel   = 2'd0;
      word_sel  = '0;
      data_we   = 1'b0;
      tag_we    = 1'b0;
      fill_done = 1'b0;

      case (state_q)
         IDLE: begin
            cpu_stall = cpu_req;
            if (cpu_req) begin
               addr_d  = cpu_addr[ADDR_WIDTH-1:OFFSET];
               state_d = LOOKUP;
            end
         end

         LOOKUP: begin
            cache_en = 1'b1;
            if (hit) begin
               way_sel = hit_way;
               state_d = IDLE;
            end else begin
               cpu_stall = 1'b1;
               // A "no victim" answer on a miss is illegal; hold and re-ask.
               if (!replaced_way[2]) begin
                  way_sel = replaced_way[1:0];
                  way_d   = replaced_way[1:0];
                  vtag_d  = victim_tag;
                  cnt_d   = '0;
                  state_d = victim_dirty ? WBACK : REFILL;
               end
            end
         end

         WBACK: begin
            cpu_stall = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {vtag_q, index, cnt_q, {BYTE_W{1'b0}}};
            mem_wdata = line_rdata;
            way_sel   = way_q;
            word_sel  = cnt_q;
            if (mem_ack) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (last_beat) state_d = REFILL;
            end
         end

         REFILL: begin
            cpu_stall = 1'b1;
            mem_req   = 1'b1;
            mem_addr  = {req_tag, index, cnt_q, {BYTE_W{1'b0}}};
            way_sel   = way_q;
            word_sel  = cnt_q;
            data_we   = mem_ack;
            if (mem_ack) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (last_beat) state_d = INSTALL;
            end
         end

         INSTALL: begin
            cpu_stall = 1'b1;
            cache_en  = 1'b1;
            tag_we    = 1'b1;
            fill_done = 1'b1;
            way_sel   = way_q;
            state_d   = LOOKUP;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         way_q   <= 2'd0;
         addr_q  <= '0;
         vtag_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         way_q   <= way_d;
         addr_q  <= addr_d;
         vtag_q  <= vtag_d;
      end
   end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Randomized bench for cache_miss_ctrl: a set-level cache/memory model predicts
// every bus beat, the miss latency, and the installed line contents.
module tb_cache_miss_ctrl;
   localparam int AW = 32, DW = 32, IW = 6, WPL = 4, OFF = 4, TW = AW - IW - OFF;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic [3:0]    hit_en;
   logic [2:0]    replaced_way;
   logic          victim_dirty;
   logic [TW-1:0] victim_tag;
   logic [DW-1:0] line_rdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;
   logic          cache_en, cpu_stall, mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [1:0]    way_sel;
   logic [1:0]    word_sel;
   logic          data_we, tag_we, fill_done;

   cache_miss_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_WIDTH(IW),
      .WORDS_PER_LINE(WPL), .OFFSET(OFF), .TAG_WIDTH(TW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
      .hit_en(hit_en), .replaced_way(replaced_way), .victim_dirty(victim_dirty),
      .victim_tag(victim_tag), .line_rdata(line_rdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .cache_en(cache_en), .cpu_stall(cpu_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .way_sel(way_sel), .word_sel(word_sel), .data_we(data_we), .tag_we(tag_we),
      .fill_done(fill_done)
   );

   always #5 clk = ~clk;

   // The environment must never answer a miss lookup with "no victim".
   assert property (@(posedge clk) disable iff (!rst_n)
      (cache_en && !fill_done && hit_en == 4'b0) |-> !replaced_way[2])
      else $error("illegal replaced_way=4 on a lookup miss");

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      int            word;
   } beat_t;

   logic [TW-1:0] tags  [64][4];
   logic          valid [64][4];
   logic          dirty [64][4];
   logic [DW-1:0] data  [64][4][4];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
      return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_ctl"}, {cache_en, cpu_stall, mem_req, mem_we, data_we, tag_we,
                          fill_done, way_sel, word_sel}, 64'd0);
      chk({tag, "_maddr"}, mem_addr, 64'd0);
      chk({tag, "_wdata"}, mem_wdata, 64'd0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cpu_req = 1'b0;
         hit_en  = 4'($urandom);
         mem_ack = 1'($urandom);
         #1;
         chk("idle_req", mem_req, 0);
         chk("idle_cache_en", cache_en, 0);
         chk("idle_stall", cpu_stall, 0);
         chk("idle_wr", {data_we, tag_we, fill_done}, 0);
      end
      mem_ack = 1'b0;
      hit_en  = 4'b0;
   endtask

   task automatic run_txn(input logic [AW-1:0] addr, input logic [1:0] rep,
                          input int dlo, input int dhi, input bit drop_req,
                          input bit rst_mid);
      logic [IW-1:0] idx;
      logic [TW-1:0] tg;
      int    hw, exp_cyc, cyc, wait_left, n_tag, n_fill, reads;
      int    delay_q[$];
      beat_t exp_q[$];
      beat_t e;
      bit    done, aborted, prev_wait, prev_ack_we;
      logic [AW-1:0] prev_addr;

      idx = addr[OFF+IW-1:OFF];
      tg  = addr[AW-1:OFF+IW];
      hw  = -1;
      for (int w = 3; w >= 0; w--)
         if (valid[idx][w] && tags[idx][w] == tg) hw = w;

      if (hw < 0) begin
         if (valid[idx][rep] && dirty[idx][rep])
            for (int k = 0; k < WPL; k++)
               exp_q.push_back('{1'b1, {tags[idx][rep], idx, 2'(k), 2'b00},
                                 data[idx][rep][k], k});
         for (int k = 0; k < WPL; k++)
            exp_q.push_back('{1'b0, {tg, idx, 2'(k), 2'b00}, '0, k});
         exp_cyc = 4;
         foreach (exp_q[k]) begin
            delay_q.push_back(dlo + int'($urandom % (dhi - dlo + 1)));
            exp_cyc += delay_q[k] + 1;
         end
      end else begin
         exp_cyc = 2;
      end

      cyc = 0; wait_left = -1; n_tag = 0; n_fill = 0; reads = 0;
      done = 0; aborted = 0; prev_wait = 0; prev_ack_we = 0; prev_addr = '0;

      while (!done && !aborted && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            cpu_req  = 1'b1;
            cpu_addr = addr;
         end
         if (drop_req && mem_req && !mem_we) cpu_req = 1'b0;
         hit_en = 4'b0;
         if (cache_en && !fill_done)
            for (int w = 0; w < 4; w++)
               hit_en[w] = valid[idx][w] && tags[idx][w] == tg;
         replaced_way = {1'b0, rep};
         victim_dirty = valid[idx][rep] && dirty[idx][rep];
         victim_tag   = tags[idx][rep];
         line_rdata   = data[idx][way_sel][word_sel];
         mem_rdata    = memf(mem_addr);
         if (mem_req) begin
            if (wait_left < 0) wait_left = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
            if (wait_left == 0) begin
               mem_ack = 1'b1;
               wait_left = -1;
            end else begin
               mem_ack = 1'b0;
               wait_left--;
            end
         end else begin
            mem_ack = ($urandom % 4 == 0);
         end
         #1;

         if (cyc == 1) chk("req_stall", cpu_stall, 1);
         if (prev_wait) begin
            chk("req_hold", mem_req, 1);
            chk("addr_hold", mem_addr, prev_addr);
         end
         if (prev_ack_we && exp_q.size() > 0) chk("no_gap", mem_req, 1);

         if (mem_req && mem_ack) begin
            if (exp_q.size() == 0) begin
               chk("extra_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("beat_we", mem_we, e.we);
               chk("beat_addr", mem_addr, e.addr);
               if (e.we) chk("beat_wdata", mem_wdata, e.wd);
               chk("beat_word", word_sel, e.word);
               chk("beat_way", way_sel, rep);
               chk("beat_data_we", data_we, !e.we);
               if (!e.we) reads++;
            end
         end else begin
            chk("data_we_quiet", data_we, 0);
         end
         if (data_we) data[idx][way_sel][word_sel] = mem_rdata;
         if (tag_we) begin
            n_tag++;
            chk("install_way", way_sel, rep);
            tags[idx][way_sel]  = tg;
            valid[idx][way_sel] = 1'b1;
            dirty[idx][way_sel] = 1'b0;
         end
         if (fill_done) n_fill++;

         prev_wait   = mem_req && !mem_ack;
         prev_ack_we = mem_req && mem_ack && mem_we;
         prev_addr   = mem_addr;

         if (cache_en && !fill_done && !cpu_stall) begin
            done = 1;
            chk("hit_way", way_sel, (hw < 0) ? rep : hw);
         end

         if (rst_mid && reads == 1 && mem_req && !mem_we && !mem_ack) begin
            rst_n   = 1'b0;
            cpu_req = 1'b0;
            mem_ack = 1'b0;
            #1;
            check_all_zero("rst_mid");
            chk("rst_no_tag", n_tag, 0);
            valid[idx][rep] = 1'b0;
            dirty[idx][rep] = 1'b0;
            @(negedge clk);
            rst_n   = 1'b1;
            aborted = 1;
         end
      end

      mem_ack = 1'b0;
      if (aborted) return;
      if (!done) begin
         chk("timeout", 0, 1);
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         return;
      end
      chk("cycles", cyc, exp_cyc);
      chk("beats_left", exp_q.size(), 0);
      chk("tag_we_cnt", n_tag, (hw < 0) ? 1 : 0);
      chk("fill_cnt", n_fill, (hw < 0) ? 1 : 0);
      if (hw < 0) begin
         for (int k = 0; k < WPL; k++)
            chk("line_data", data[idx][rep][k], memf({tg, idx, 2'(k), 2'b00}));
      end else if ($urandom % 2 == 1) begin
         dirty[idx][hw] = 1'b1;
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++)
         for (int w = 0; w < 4; w++) begin
            valid[i][w] = 1'($urandom);
            dirty[i][w] = valid[i][w] & 1'($urandom);
            tags[i][w]  = TW'(($urandom % 2) * 4 + w);
            for (int k = 0; k < 4; k++) data[i][w][k] = $urandom;
         end

      rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0; hit_en = '0; replaced_way = '0;
      victim_dirty = 1'b0; victim_tag = '0; line_rdata = '0; mem_ack = 1'b0;
      mem_rdata = '0;
      #1;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle_cycles(2);

      // hit on way 1 at 0x40
      valid[4][1] = 1'b1; tags[4][1] = '0;
      valid[4][0] = 1'b0;
      run_txn(32'h0000_0040, 2'd3, 0, 0, 0, 0);

      // clean miss into way 2, back-to-back acks
      valid[32'h1234_5670 >> 4 & 63][2] = 1'b0;
      run_txn(32'h1234_5670, 2'd2, 0, 0, 0, 0);

      // dirty victim with tag 0xABCDE at index 0x27
      valid[6'h27][1] = 1'b1; dirty[6'h27][1] = 1'b1; tags[6'h27][1] = TW'(22'hABCDE);
      run_txn({22'h1, 6'h27, 4'h0}, 2'd1, 0, 0, 0, 0);

      // slow bus: three wait cycles before each ack
      valid[6'h11][0] = 1'b1; dirty[6'h11][0] = 1'b1;
      run_txn({22'h9, 6'h11, 4'h8}, 2'd0, 3, 3, 0, 0);

      // reset during the second refill beat, then a full refill of the same line
      valid[6'h05][3] = 1'b0;
      run_txn({22'h3A, 6'h05, 4'h0}, 2'd3, 1, 2, 0, 1);
      idle_cycles(1);
      run_txn({22'h3A, 6'h05, 4'h0}, 2'd3, 0, 1, 0, 0);

      // request dropped mid-refill, spurious acks while idle
      run_txn({22'h5, 6'h09, 4'h4}, 2'd2, 0, 2, 1, 0);
      idle_cycles(4);

      for (int t = 0; t < 40; t++) begin
         run_txn({22'($urandom % 8), 6'($urandom % 8), 4'($urandom)},
                 2'($urandom), 0, 2, bit'($urandom % 4 == 0), 0);
         if ($urandom % 2 == 1) idle_cycles(1 + $urandom % 2);
      end

      idle_cycles(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
